// File: rtl/operacion_seq.sv
// operacion_seq: registered six-opcode arithmetic unit with valid/ready
// handshakes on both sides. Multiply opcodes (2, 3) run an iterative
// shift-add multiplier over WIDTH cycles; all other opcodes finish in one.
module operacion_seq #(
  parameter int WIDTH = 8,
  parameter int SHIFT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         sel,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [WIDTH-1:0]   C,
  input  logic [WIDTH-1:0]   D,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] res,
  output logic               err,
  output logic               busy
);

  localparam int RW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } state_t;

  state_t state, state_next;

  logic [RW-1:0]    a_ext, b_ext, c_ext, d_ext;
  logic [RW-1:0]    single_res;
  logic             single_err;
  logic             accept;
  logic             is_mul;
  logic             mul_last;

  logic [RW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [RW-1:0]    acc;
  logic [RW-1:0]    acc_next;
  logic [RW-1:0]    c_hold;
  logic             sub_c;
  logic [CW-1:0]    count;

  // Handshake/status outputs and zero-extended operands
  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    busy      = (state != IDLE);
    out_valid = (state == DONE);
    accept    = in_valid && in_ready;
    is_mul    = (sel == 3'd2) || (sel == 3'd3);
    mul_last  = (count == CW'(WIDTH - 1));
    a_ext     = {{WIDTH{1'b0}}, A};
    b_ext     = {{WIDTH{1'b0}}, B};
    c_ext     = {{WIDTH{1'b0}}, C};
    d_ext     = {{WIDTH{1'b0}}, D};
  end

  // Single-cycle opcode results, computed straight from the accepted inputs
  always_comb begin
    single_res = '0;
    single_err = 1'b0;
    case (sel)
      3'd0:    single_res = a_ext + b_ext - c_ext;
      3'd1:    single_res = d_ext << SHIFT;
      3'd4:    single_res = RW'(C[0]);
      3'd5:    single_res = b_ext + c_ext;
      3'd6,
      3'd7:    single_err = 1'b1;
      default: single_res = '0;
    endcase
  end

  // One shift-add step: the multiplicand is kept pre-shifted by count and the
  // multiplier shifted right, so bit count always sits at mplier[0].
  always_comb begin
    acc_next = acc + (mplier[0] ? mcand : '0);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = is_mul ? MUL : DONE;
      MUL:     if (mul_last) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, multiplier iteration and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      res    <= '0;
      err    <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      c_hold <= '0;
      sub_c  <= 1'b0;
      count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_mul) begin
              mcand  <= (sel == 3'd2) ? a_ext : d_ext;
              mplier <= (sel == 3'd2) ? C : D;
              acc    <= '0;
              count  <= '0;
              c_hold <= c_ext;
              sub_c  <= (sel == 3'd2);
            end else begin
              res <= single_res;
              err <= single_err;
            end
          end
        end
        MUL: begin
          if (mul_last) begin
            res <= acc_next - (sub_c ? c_hold : '0);
            err <= 1'b0;
          end else begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_operacion_seq.sv
// Self-checking bench for operacion_seq: directed cases followed by random
// operations compared against an arithmetic reference model.
module tb_operacion_seq;

  localparam int W  = 8;
  localparam int SH = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    sel;
  logic [W-1:0]  A, B, C, D;
  logic          out_valid;
  logic          out_ready;
  logic [2*W-1:0] res;
  logic          err;
  logic          busy;

  int vectors = 0;
  int miscompares = 0;

  operacion_seq #(.WIDTH(W), .SHIFT(SH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .A(A), .B(B), .C(C), .D(D),
    .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  // Reference model: plain arithmetic modulo 2^16
  function automatic logic [15:0] model(input logic [2:0] s, input logic [7:0] a,
                                        input logic [7:0] b, input logic [7:0] c,
                                        input logic [7:0] d);
    longint r;
    case (s)
      3'd0:    r = longint'(a) + longint'(b) - longint'(c);
      3'd1:    r = longint'(d) << SH;
      3'd2:    r = longint'(a) * longint'(c) - longint'(c);
      3'd3:    r = longint'(d) * longint'(d);
      3'd4:    r = longint'(c) % 2;
      3'd5:    r = longint'(b) + longint'(c);
      default: r = 0;
    endcase
    return r[15:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one op, check latency/result, then hold off or release the consumer
  task automatic run_op(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] d,
                        input int hold, input bit early);
    logic [15:0] exp_res;
    int exp_lat;
    int lat;
    exp_res = model(s, a, b, c, d);
    exp_lat = (s == 3'd2 || s == 3'd3) ? W + 1 : 1;
    @(negedge clk);
    sel = s; A = a; B = b; C = c; D = d;
    in_valid = 1'b1; out_ready = 1'b0;
    check("in_ready_idle", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    sel = 3'($urandom_range(0, 7)); A = 8'($urandom); B = 8'($urandom);
    C = 8'($urandom); D = 8'($urandom);
    if (early) out_ready = 1'b1;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("res", 32'(res), 32'(exp_res));
    check("err", 32'(err), 32'(s > 3'd5));
    check("in_ready_busy", 32'(in_ready), 32'd0);
    if (early) begin
      @(posedge clk); #1;
      check("one_cycle_valid", 32'(out_valid), 32'd0);
      out_ready = 1'b0;
    end else begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_res", 32'(res), 32'(exp_res));
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("valid_drop", 32'(out_valid), 32'd0);
      out_ready = 1'b0;
    end
  endtask

  initial begin
    bit saw_valid;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    sel = '0; A = '0; B = '0; C = '0; D = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_res", 32'(res), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Directed cases
    run_op(3'd0, 8'd10, 8'd20, 8'd5, 8'd0, 0, 1'b0);
    run_op(3'd0, 8'd0, 8'd0, 8'd1, 8'd0, 1, 1'b0);
    run_op(3'd1, 8'd0, 8'd0, 8'd0, 8'hFF, 0, 1'b0);
    run_op(3'd4, 8'd0, 8'd0, 8'd7, 8'd0, 0, 1'b0);
    run_op(3'd5, 8'd0, 8'd200, 8'd100, 8'd0, 0, 1'b0);
    run_op(3'd3, 8'd0, 8'd0, 8'd0, 8'd255, 0, 1'b0);
    run_op(3'd2, 8'd255, 8'd0, 8'd255, 8'd0, 0, 1'b0);
    run_op(3'd2, 8'd0, 8'd0, 8'd3, 8'd0, 0, 1'b1);
    run_op(3'd7, 8'd1, 8'd2, 8'd3, 8'd4, 0, 1'b0);
    run_op(3'd5, 8'd1, 8'd2, 8'd3, 8'd4, 0, 1'b0);

    // Backpressure: new request held while the result is stalled
    @(negedge clk);
    sel = 3'd5; B = 8'd200; C = 8'd100; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    sel = 3'd0; A = 8'd9; B = 8'd4; C = 8'd3;
    check("bp_first_res", 32'(res), 32'd300);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp_stable_res", 32'(res), 32'd300);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_second_valid", 32'(out_valid), 32'd1);
    check("bp_second_res", 32'(res), 32'd10);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset during a multiply aborts it without a result
    @(negedge clk);
    sel = 3'd3; D = 8'd200; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_res", 32'(res), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    saw_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) saw_valid = 1'b1;
    end
    check("midrst_no_valid", 32'(saw_valid), 32'd0);
    run_op(3'd0, 8'd100, 8'd50, 8'd25, 8'd0, 0, 1'b0);

    // Random operations
    for (int n = 0; n < 40; n++) begin
      run_op(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 8'($urandom),
             8'($urandom), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
